// File: rtl/key_expander_pkg.sv
// Shared AES-128 cipher types, round constants and FSM encodings for the key expander.
package key_expander_pkg;

    typedef logic [7:0]   aes_byte_t;
    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_key_t;

    localparam logic [5:0] LastIdx = 6'd43;

    localparam logic StIdle = 1'b0;
    localparam logic StEmit = 1'b1;

    // Indexed by round number (word index / 4); only entries 1..10 are ever selected.
    localparam aes_byte_t RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic aes_word_t rot_word(input aes_word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/key_expander_if.sv
// Start/key request and round-key word stream between the key expander and its consumer.
interface key_expander_if;
    import key_expander_pkg::*;

    logic       start;
    aes_key_t   key_in;
    logic       rk_valid;
    logic       rk_ready;
    aes_word_t  rk_word;
    logic [5:0] rk_index;
    logic       busy;
    logic       done;

    modport master (
        output start, key_in, rk_ready,
        input  rk_valid, rk_word, rk_index, busy, done
    );

    modport slave (
        input  start, key_in, rk_ready,
        output rk_valid, rk_word, rk_index, busy, done
    );

endinterface

// File: rtl/key_expander_subword.sv
// AES SubWord: four parallel forward S-box lookups, purely combinational.
module key_expander_subword
    import key_expander_pkg::*;
(
    input  aes_word_t word_i,
    output aes_word_t word_o
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign word_o[31:24] = SBOX[word_i[31:24]];
    assign word_o[23:16] = SBOX[word_i[23:16]];
    assign word_o[15:8]  = SBOX[word_i[15:8]];
    assign word_o[7:0]   = SBOX[word_i[7:0]];

endmodule

// File: rtl/key_expander.sv
// AES-128 key schedule generator: streams w[0..43] one word per accepted transfer,
// keeping only a sliding four-word window of the schedule.
module key_expander
    import key_expander_pkg::*;
(
    input logic           clk,
    input logic           rst,
    key_expander_if.slave bus
);

    logic       state_q, state_d;
    logic [5:0] idx_q, idx_d;
    logic       done_q, done_d;
    aes_word_t  win_q [4];
    aes_word_t  win_d [4];

    aes_word_t rot;
    aes_word_t sub_rot;
    aes_word_t temp;
    aes_word_t word;

    assign rot = rot_word(win_q[3]);

    key_expander_subword u_subword (
        .word_i (rot),
        .word_o (sub_rot)
    );

    // Words 0..3 are the key itself; later words are derived from the window.
    always_comb begin
        temp = win_q[3];
        if (idx_q[1:0] == 2'd0) begin
            temp = sub_rot ^ {RCON[idx_q[5:2]], 24'h000000};
        end
        word = (idx_q < 6'd4) ? win_q[idx_q[1:0]] : (win_q[0] ^ temp);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        win_d   = win_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d  = StEmit;
                    idx_d    = '0;
                    win_d[0] = bus.key_in[127:96];
                    win_d[1] = bus.key_in[95:64];
                    win_d[2] = bus.key_in[63:32];
                    win_d[3] = bus.key_in[31:0];
                end
            end
            StEmit: begin
                if (bus.rk_ready) begin
                    idx_d = idx_q + 6'd1;
                    if (idx_q >= 6'd4) begin
                        win_d[0] = win_q[1];
                        win_d[1] = win_q[2];
                        win_d[2] = win_q[3];
                        win_d[3] = word;
                    end
                    if (idx_q == LastIdx) begin
                        state_d = StIdle;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            for (int i = 0; i < 4; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    assign bus.rk_valid = (state_q == StEmit);
    assign bus.busy     = (state_q == StEmit);
    assign bus.done     = done_q;
    assign bus.rk_word  = (state_q == StEmit) ? word : '0;
    assign bus.rk_index = (state_q == StEmit) ? idx_q : '0;

endmodule

// File: tb/tb_key_expander.sv
// Self-checking bench for key_expander: reference schedule built from a GF(2^8) model,
// expected words queued at start and compared as the DUT transfers them.
module tb_key_expander;
    import key_expander_pkg::*;

    localparam aes_key_t FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [37:0] sb [$];
    aes_word_t   mw [44];

    always #5 clk = ~clk;

    key_expander_if bus ();

    key_expander dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic aes_byte_t gmul(input aes_byte_t a, input aes_byte_t b);
        aes_byte_t p;
        aes_byte_t x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse then the affine map.
    function automatic aes_byte_t sbox_ref(input aes_byte_t x);
        aes_byte_t inv;
        aes_byte_t s;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        s = 8'h63 ^ inv;
        for (int n = 1; n < 5; n++) s = s ^ ((inv << n) | (inv >> (8 - n)));
        return s;
    endfunction

    task automatic expand_ref(input aes_key_t key);
        aes_word_t t;
        aes_byte_t rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) mw[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = mw[i - 1];
            if (i % 4 == 0) begin
                t = {sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0]),
                     sbox_ref(t[31:24])} ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            mw[i] = mw[i - 4] ^ t;
        end
    endtask

    task automatic push_exp(input aes_key_t key);
        expand_ref(key);
        for (int i = 0; i < 44; i++) sb.push_back({6'(i), mw[i]});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        bus.key_in = FipsKey;
        bus.rk_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.rk_valid, bus.busy, bus.done} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags: got v/b/d=%b want 000", {bus.rk_valid, bus.busy, bus.done});
        end
        n_cmp++;
        if (bus.rk_index !== 6'd0 || bus.rk_word !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got idx=%0d w=%h want idx=0 w=0",
                     bus.rk_index, bus.rk_word);
        end
        rst = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.rk_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: got v=%b want 0", bus.rk_valid);
        end
    endtask

    task automatic test_fips_stream();
        int          kidx [5] = '{4, 5, 7, 40, 43};
        aes_word_t   kval [5] = '{32'ha0fafe17, 32'h88542cb1, 32'h2a6c7605, 32'hd014f9a8,
                                  32'hb6630ca6};
        logic [37:0] e;
        bus.rk_ready = 1'b1;
        bus.key_in = FipsKey;
        bus.start = 1'b1;
        push_exp(FipsKey);
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 44; c++) begin
            e = sb.pop_front();
            n_cmp++;
            if (bus.rk_valid !== 1'b1 || bus.rk_index !== e[37:32] || bus.rk_word !== e[31:0]) begin
                n_err++;
                $display("FAIL fips_stream: got v=%b idx=%0d w=%h want v=1 idx=%0d w=%h",
                         bus.rk_valid, bus.rk_index, bus.rk_word, e[37:32], e[31:0]);
            end
            for (int k = 0; k < 5; k++) begin
                if (e[37:32] == 6'(kidx[k])) begin
                    n_cmp++;
                    if (bus.rk_word !== kval[k]) begin
                        n_err++;
                        $display("FAIL fips_vector w%0d: got %h want %h",
                                 kidx[k], bus.rk_word, kval[k]);
                    end
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({bus.done, bus.rk_valid, bus.busy} !== 3'b100) begin
            n_err++;
            $display("FAIL fips_done: got d/v/b=%b want 100", {bus.done, bus.rk_valid, bus.busy});
        end
        n_cmp++;
        if (bus.rk_word !== 32'h0 || bus.rk_index !== 6'd0) begin
            n_err++;
            $display("FAIL fips_idle_zero: got idx=%0d w=%h want 0/0", bus.rk_index, bus.rk_word);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL fips_done_pulse: got %b want 0", bus.done);
        end
    endtask

    task automatic test_zero_key();
        int          kidx [8] = '{4, 5, 6, 7, 40, 41, 42, 43};
        aes_word_t   kval [8] = '{32'h62636363, 32'h62636363, 32'h62636363, 32'h62636363,
                                  32'hb4ef5bcb, 32'h3e92e211, 32'h23e951cf, 32'h6f8f188e};
        logic [37:0] e;
        bus.rk_ready = 1'b1;
        bus.key_in = '0;
        bus.start = 1'b1;
        push_exp('0);
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 44; c++) begin
            e = sb.pop_front();
            n_cmp++;
            if (bus.rk_valid !== 1'b1 || bus.rk_index !== e[37:32] || bus.rk_word !== e[31:0]) begin
                n_err++;
                $display("FAIL zero_stream: got v=%b idx=%0d w=%h want v=1 idx=%0d w=%h",
                         bus.rk_valid, bus.rk_index, bus.rk_word, e[37:32], e[31:0]);
            end
            for (int k = 0; k < 8; k++) begin
                if (e[37:32] == 6'(kidx[k])) begin
                    n_cmp++;
                    if (bus.rk_word !== kval[k]) begin
                        n_err++;
                        $display("FAIL zero_vector w%0d: got %h want %h",
                                 kidx[k], bus.rk_word, kval[k]);
                    end
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (bus.done !== 1'b1) begin
            n_err++;
            $display("FAIL zero_done: got %b want 1", bus.done);
        end
        @(negedge clk);
    endtask

    task automatic test_stall_and_start();
        logic [37:0] e;
        int          stalls = 0;
        bit          poked = 1'b0;
        bus.rk_ready = 1'b1;
        bus.key_in = FipsKey;
        bus.start = 1'b1;
        push_exp(FipsKey);
        @(negedge clk);
        for (int c = 0; c < 80 && sb.size() > 0; c++) begin
            bus.start = 1'b0;
            bus.key_in = FipsKey;
            if (bus.rk_valid && bus.rk_index == 6'd4 && stalls < 3) begin
                bus.rk_ready = 1'b0;
                stalls++;
                n_cmp++;
                if (bus.rk_word !== 32'ha0fafe17) begin
                    n_err++;
                    $display("FAIL stall_hold: got %h want a0fafe17", bus.rk_word);
                end
            end else begin
                bus.rk_ready = 1'b1;
            end
            if (bus.rk_valid && bus.rk_index == 6'd10 && !poked) begin
                bus.start = 1'b1;
                bus.key_in = ~FipsKey;
                poked = 1'b1;
            end
            if (bus.rk_valid && bus.rk_ready) begin
                e = sb.pop_front();
                n_cmp++;
                if (bus.rk_index !== e[37:32] || bus.rk_word !== e[31:0]) begin
                    n_err++;
                    $display("FAIL stall_stream: got idx=%0d w=%h want idx=%0d w=%h",
                             bus.rk_index, bus.rk_word, e[37:32], e[31:0]);
                end
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.rk_ready = 1'b1;
        n_cmp++;
        if (stalls != 3) begin
            n_err++;
            $display("FAIL stall_count: got %0d held cycles at index 4 want 3", stalls);
        end
        n_cmp++;
        if (sb.size() != 0 || bus.done !== 1'b1) begin
            n_err++;
            $display("FAIL stall_finish: got left=%0d done=%b want left=0 done=1",
                     sb.size(), bus.done);
        end
        sb.delete();
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [37:0] e;
        aes_key_t    k2;
        k2 = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.rk_ready = 1'b1;
        bus.key_in = FipsKey;
        bus.start = 1'b1;
        push_exp(FipsKey);
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 60 && bus.rk_index != 6'd20; c++) begin
            e = sb.pop_front();
            n_cmp++;
            if (bus.rk_index !== e[37:32] || bus.rk_word !== e[31:0]) begin
                n_err++;
                $display("FAIL rstmid_stream: got idx=%0d w=%h want idx=%0d w=%h",
                         bus.rk_index, bus.rk_word, e[37:32], e[31:0]);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({bus.rk_valid, bus.busy, bus.done} !== 3'b000 || bus.rk_index !== 6'd0) begin
            n_err++;
            $display("FAIL rstmid_clear: got v/b/d=%b idx=%0d want 000 idx=0",
                     {bus.rk_valid, bus.busy, bus.done}, bus.rk_index);
        end
        sb.delete();
        bus.key_in = k2;
        bus.start = 1'b1;
        push_exp(k2);
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 44; c++) begin
            e = sb.pop_front();
            n_cmp++;
            if (bus.rk_valid !== 1'b1 || bus.rk_index !== e[37:32] || bus.rk_word !== e[31:0]) begin
                n_err++;
                $display("FAIL rstmid_restart: got v=%b idx=%0d w=%h want v=1 idx=%0d w=%h",
                         bus.rk_valid, bus.rk_index, bus.rk_word, e[37:32], e[31:0]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (bus.done !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_done: got %b want 1", bus.done);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [37:0] e;
        aes_key_t    ka;
        aes_key_t    kb;
        ka = {$urandom(), $urandom(), $urandom(), $urandom()};
        kb = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.rk_ready = 1'b1;
        bus.key_in = ka;
        bus.start = 1'b1;
        push_exp(ka);
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 44; c++) begin
            e = sb.pop_front();
            n_cmp++;
            if (bus.rk_valid !== 1'b1 || bus.rk_index !== e[37:32] || bus.rk_word !== e[31:0]) begin
                n_err++;
                $display("FAIL b2b_first: got v=%b idx=%0d w=%h want v=1 idx=%0d w=%h",
                         bus.rk_valid, bus.rk_index, bus.rk_word, e[37:32], e[31:0]);
            end
            if (c == 43) begin
                bus.start = 1'b1;
                bus.key_in = kb;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (bus.done !== 1'b1 || bus.rk_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_done: got d=%b v=%b want d=1 v=0", bus.done, bus.rk_valid);
        end
        push_exp(kb);
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 44; c++) begin
            e = sb.pop_front();
            n_cmp++;
            if (bus.rk_valid !== 1'b1 || bus.rk_index !== e[37:32] || bus.rk_word !== e[31:0]) begin
                n_err++;
                $display("FAIL b2b_second: got v=%b idx=%0d w=%h want v=1 idx=%0d w=%h",
                         bus.rk_valid, bus.rk_index, bus.rk_word, e[37:32], e[31:0]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_second_done: got d=%b b=%b want d=1 b=0", bus.done, bus.busy);
        end
        @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.key_in = '0;
        bus.rk_ready = 1'b0;
        test_reset();
        test_fips_stream();
        test_zero_key();
        test_stall_and_start();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
